int_div_pre_norm: RTL



---
 rtl/int_div_pre_norm.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/int_div_pre_norm.sv
// Integer divider pre-normalisation stage.
// Takes a dividend/divisor pair, strips the signs, counts leading zeros and
// left-justifies both magnitudes so a radix-16 iterative divider can start
// directly on normalised operands. Also derives the iteration count and the
// sign/zero flags the divider core needs.
//
// Handshake (both ports): a transfer happens on a rising clk edge where
// valid and ready are both 1. The input side also requires !flush_i. The
// producer holds valid and its data until the transfer. Once out_valid_o
// rises it stays high with every output stable until out_ready_i is seen,
// unless a flush or reset intervenes.

// Leading/trailing zero counter. MODE=1 counts from the MSB, MODE=0 from the
// LSB. An all-zero input reports WIDTH-1 with empty_o set.
module lzc #(
  parameter int WIDTH     = 64,
  parameter bit MODE      = 1'b1,
  parameter int CNT_WIDTH = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]     in_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 empty_o
);

  logic [WIDTH-1:0] scan;
  logic             found;

  // Present the bits in scan order so one priority loop serves both modes.
  always_comb begin
    scan = '0;
    for (int i = 0; i < WIDTH; i++) begin
      scan[i] = MODE ? in_i[WIDTH-1-i] : in_i[i];
    end
  end

  // First set bit in scan order gives the count.
  always_comb begin
    cnt_o   = CNT_WIDTH'(WIDTH - 1);
    found   = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (!found && scan[i]) begin
        cnt_o = CNT_WIDTH'(i);
        found = 1'b1;
      end
    end
    empty_o = ~|in_i;
  end

endmodule

module int_div_pre_norm #(
  parameter int WIDTH      = 64,
  parameter int CNT_WIDTH  = $clog2(WIDTH),
  parameter int ITER_WIDTH = $clog2(WIDTH/4) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  input  logic                  start_valid_i,
  output logic                  start_ready_o,
  input  logic                  signed_op_i,
  input  logic [WIDTH-1:0]      dividend_i,
  input  logic [WIDTH-1:0]      divisor_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [WIDTH-1:0]      dividend_norm_o,
  output logic [WIDTH-1:0]      divisor_norm_o,
  output logic [CNT_WIDTH-1:0]  dividend_lzc_o,
  output logic [CNT_WIDTH-1:0]  divisor_lzc_o,
  output logic [ITER_WIDTH-1:0] iter_num_o,
  output logic                  quo_sign_o,
  output logic                  rem_sign_o,
  output logic                  div_by_zero_o,
  output logic                  early_finish_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LZC  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                state_q;
  logic                  start_ready_q;
  logic                  out_valid_q;

  // Captured operand magnitudes and signs.
  logic [WIDTH-1:0]      a_abs_q;
  logic [WIDTH-1:0]      b_abs_q;
  logic                  sign_a_q;
  logic                  sign_b_q;
  logic                  signed_q;

  // Leading-zero results captured in LZC.
  logic [CNT_WIDTH-1:0]  a_lzc_q;
  logic [CNT_WIDTH-1:0]  b_lzc_q;
  logic                  a_zero_q;
  logic                  b_zero_q;

  // Output registers.
  logic [WIDTH-1:0]      dividend_norm_q;
  logic [WIDTH-1:0]      divisor_norm_q;
  logic [CNT_WIDTH-1:0]  dividend_lzc_q;
  logic [CNT_WIDTH-1:0]  divisor_lzc_q;
  logic [ITER_WIDTH-1:0] iter_num_q;
  logic                  quo_sign_q;
  logic                  rem_sign_q;
  logic                  div_by_zero_q;
  logic                  early_finish_q;

  // Combinational helpers.
  logic                  a_neg;
  logic                  b_neg;
  logic [WIDTH-1:0]      a_abs;
  logic [WIDTH-1:0]      b_abs;
  logic [CNT_WIDTH-1:0]  a_lzc;
  logic [CNT_WIDTH-1:0]  b_lzc;
  logic                  a_empty;
  logic                  b_empty;
  logic                  early_finish;
  logic [CNT_WIDTH:0]    qb_plus3;
  logic [ITER_WIDTH-1:0] iter_num;

  // Magnitudes: negating -2^(WIDTH-1) wraps to 2^(WIDTH-1), which is the
  // correct unsigned magnitude, so no special case is needed.
  always_comb begin
    a_neg = signed_op_i & dividend_i[WIDTH-1];
    b_neg = signed_op_i & divisor_i[WIDTH-1];
    a_abs = a_neg ? (WIDTH'(0) - dividend_i) : dividend_i;
    b_abs = b_neg ? (WIDTH'(0) - divisor_i)  : divisor_i;
  end

  lzc #(.WIDTH(WIDTH), .MODE(1'b1), .CNT_WIDTH(CNT_WIDTH)) u_lzc_a (
    .in_i    (a_abs_q),
    .cnt_o   (a_lzc),
    .empty_o (a_empty)
  );

  lzc #(.WIDTH(WIDTH), .MODE(1'b1), .CNT_WIDTH(CNT_WIDTH)) u_lzc_b (
    .in_i    (b_abs_q),
    .cnt_o   (b_lzc),
    .empty_o (b_empty)
  );

  // Iteration count: qb = b_lzc - a_lzc + 1 quotient bits, four per
  // radix-16 step, rounded up; forced to zero when nothing is left to do.
  always_comb begin
    early_finish = b_zero_q | a_zero_q | (a_lzc_q > b_lzc_q);
    qb_plus3     = {1'b0, b_lzc_q} - {1'b0, a_lzc_q} + (CNT_WIDTH+1)'(4);
    iter_num     = early_finish ? '0 : ITER_WIDTH'(qb_plus3 >> 2);
  end

  // Control FSM and all pipeline/output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      start_ready_q   <= 1'b1;
      out_valid_q     <= 1'b0;
      a_abs_q         <= '0;
      b_abs_q         <= '0;
      sign_a_q        <= 1'b0;
      sign_b_q        <= 1'b0;
      signed_q        <= 1'b0;
      a_lzc_q         <= '0;
      b_lzc_q         <= '0;
      a_zero_q        <= 1'b0;
      b_zero_q        <= 1'b0;
      dividend_norm_q <= '0;
      divisor_norm_q  <= '0;
      dividend_lzc_q  <= '0;
      divisor_lzc_q   <= '0;
      iter_num_q      <= '0;
      quo_sign_q      <= 1'b0;
      rem_sign_q      <= 1'b0;
      div_by_zero_q   <= 1'b0;
      early_finish_q  <= 1'b0;
    end else if (flush_i) begin
      state_q       <= IDLE;
      start_ready_q <= 1'b1;
      out_valid_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_valid_i) begin
            a_abs_q       <= a_abs;
            b_abs_q       <= b_abs;
            sign_a_q      <= dividend_i[WIDTH-1];
            sign_b_q      <= divisor_i[WIDTH-1];
            signed_q      <= signed_op_i;
            start_ready_q <= 1'b0;
            state_q       <= LZC;
          end
        end
        LZC: begin
          a_lzc_q  <= a_lzc;
          b_lzc_q  <= b_lzc;
          a_zero_q <= a_empty;
          b_zero_q <= b_empty;
          state_q  <= NORM;
        end
        NORM: begin
          dividend_norm_q <= a_abs_q << a_lzc_q;
          divisor_norm_q  <= b_abs_q << b_lzc_q;
          dividend_lzc_q  <= a_lzc_q;
          divisor_lzc_q   <= b_lzc_q;
          iter_num_q      <= iter_num;
          early_finish_q  <= early_finish;
          div_by_zero_q   <= b_zero_q;
          quo_sign_q      <= signed_q & (sign_a_q ^ sign_b_q) & ~b_zero_q;
          rem_sign_q      <= signed_q & sign_a_q & ~a_zero_q;
          out_valid_q     <= 1'b1;
          state_q         <= DONE;
        end
        DONE: begin
          if (out_ready_i) begin
            out_valid_q   <= 1'b0;
            start_ready_q <= 1'b1;
            state_q       <= IDLE;
          end
        end
        default: begin
          out_valid_q   <= 1'b0;
          start_ready_q <= 1'b1;
          state_q       <= IDLE;
        end
      endcase
    end
  end

  assign start_ready_o   = start_ready_q;
  assign out_valid_o     = out_valid_q;
  assign dividend_norm_o = dividend_norm_q;
  assign divisor_norm_o  = divisor_norm_q;
  assign dividend_lzc_o  = dividend_lzc_q;
  assign divisor_lzc_o   = divisor_lzc_q;
  assign iter_num_o      = iter_num_q;
  assign quo_sign_o      = quo_sign_q;
  assign rem_sign_o      = rem_sign_q;
  assign div_by_zero_o   = div_by_zero_q;
  assign early_finish_o  = early_finish_q;

endmodule
